// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronizes, debounces and edge-detects board buttons and switches
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SW_WIDTH        = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run_raw,
    input  logic                rab_raw,
    input  logic [SW_WIDTH-1:0] sw_raw,
    output logic                run_level,
    output logic                run_pulse,
    output logic                rab_level,
    output logic                rab_pulse,
    output logic [SW_WIDTH-1:0] sw_sync
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // Button channel 0 is run, channel 1 is rab.
    logic [1:0]          btn_raw;
    logic [1:0]          btn_s1_q;
    logic [1:0]          btn_s2_q;
    logic [1:0]          stable_q;
    logic [1:0]          stable_d;
    logic [1:0]          pulse_q;
    logic [1:0]          pulse_d;
    logic [1:0][CW-1:0]  cnt_q;
    logic [1:0][CW-1:0]  cnt_d;
    logic [SW_WIDTH-1:0] sw_s1_q;
    logic [SW_WIDTH-1:0] sw_s2_q;

    assign btn_raw = {rab_raw, run_raw};

    // Any cycle where the synchronized input agrees with the accepted level restarts the count.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            pulse_d[i]  = 1'b0;
            if (btn_s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = btn_s2_q[i];
                    pulse_d[i]  = btn_s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            stable_q <= '0;
            pulse_q  <= '0;
            cnt_q    <= '0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
        end else begin
            btn_s1_q <= btn_raw;
            btn_s2_q <= btn_s1_q;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
            sw_s1_q  <= sw_raw;
            sw_s2_q  <= sw_s1_q;
        end
    end

    assign run_level = stable_q[0];
    assign rab_level = stable_q[1];
    assign run_pulse = pulse_q[0];
    assign rab_pulse = pulse_q[1];
    assign sw_sync   = sw_s2_q;

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - self-checking bench for input_conditioner
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run_raw;
    logic       rab_raw;
    logic [7:0] sw_raw;
    logic       run_level;
    logic       run_pulse;
    logic       rab_level;
    logic       rab_pulse;
    logic [7:0] sw_sync;

    int tests     = 0;
    int fails     = 0;
    int mon_tests = 0;
    int mon_fails = 0;
    int cyc       = 0;
    int mon_exp;
    int run_q[$];
    int rab_q[$];

    input_conditioner #(.DEBOUNCE_CYCLES(16), .SW_WIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run_raw   (run_raw),
        .rab_raw   (rab_raw),
        .sw_raw    (sw_raw),
        .run_level (run_level),
        .run_pulse (run_pulse),
        .rab_level (rab_level),
        .rab_pulse (rab_pulse),
        .sw_sync   (sw_sync)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse scoreboard: each observed pulse must match the next expected edge number.
    always @(negedge clk) begin
        if (run_pulse === 1'b1) begin
            mon_tests++;
            if (run_q.size() == 0) begin
                mon_fails++;
                $display("FAIL run_pulse_unexpected cycle=%0d", cyc);
            end else begin
                mon_exp = run_q.pop_front();
                if (cyc !== mon_exp) begin
                    mon_fails++;
                    $display("FAIL run_pulse_time got cycle %0d expected %0d", cyc, mon_exp);
                end
            end
        end
        if (rab_pulse === 1'b1) begin
            mon_tests++;
            if (rab_q.size() == 0) begin
                mon_fails++;
                $display("FAIL rab_pulse_unexpected cycle=%0d", cyc);
            end else begin
                mon_exp = rab_q.pop_front();
                if (cyc !== mon_exp) begin
                    mon_fails++;
                    $display("FAIL rab_pulse_time got cycle %0d expected %0d", cyc, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        run_raw = 1'b1;
        rab_raw = 1'b1;
        sw_raw  = 8'hFF;
        repeat (3) begin
            tick();
            tests++;
            if ({run_level, run_pulse, rab_level, rab_pulse, sw_sync} !== 12'h000) begin
                fails++;
                $display("FAIL reset_outputs got %b expected all zero",
                         {run_level, run_pulse, rab_level, rab_pulse, sw_sync});
            end
        end
        run_raw = 1'b0;
        rab_raw = 1'b0;
        sw_raw  = 8'h00;
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        tests++;
        if ({run_level, run_pulse, rab_level, rab_pulse, sw_sync} !== 12'h000) begin
            fails++;
            $display("FAIL post_reset_idle got %b expected all zero",
                     {run_level, run_pulse, rab_level, rab_pulse, sw_sync});
        end
    endtask

    task automatic test_clean_press();
        int e0;
        int e1;
        e0 = cyc;
        run_raw = 1'b1;
        run_q.push_back(e0 + 18);
        repeat (40) begin
            tick();
            tests++;
            if (run_level !== (cyc >= e0 + 18) || rab_level !== 1'b0) begin
                fails++;
                $display("FAIL clean_press_level cycle %0d run=%b rab=%b expected run=%b rab=0",
                         cyc - e0, run_level, rab_level, cyc >= e0 + 18);
            end
        end
        e1 = cyc;
        run_raw = 1'b0;
        repeat (25) begin
            tick();
            tests++;
            if (run_level !== (cyc < e1 + 18)) begin
                fails++;
                $display("FAIL clean_release_level cycle %0d got %b expected %b",
                         cyc - e1, run_level, cyc < e1 + 18);
            end
        end
    endtask

    task automatic test_bounce();
        int e0;
        for (int i = 0; i < 30; i++) begin
            run_raw = ((i / 3) % 2 == 0);
            tick();
            tests++;
            if (run_level !== 1'b0) begin
                fails++;
                $display("FAIL bounce_level step %0d got %b expected 0", i, run_level);
            end
        end
        e0 = cyc;
        run_raw = 1'b1;
        run_q.push_back(e0 + 18);
        repeat (30) begin
            tick();
            tests++;
            if (run_level !== (cyc >= e0 + 18)) begin
                fails++;
                $display("FAIL bounce_settle_level cycle %0d got %b expected %b",
                         cyc - e0, run_level, cyc >= e0 + 18);
            end
        end
        run_raw = 1'b0;
        repeat (25) tick();
        tests++;
        if (run_level !== 1'b0) begin
            fails++;
            $display("FAIL bounce_release_level got %b expected 0", run_level);
        end
    endtask

    task automatic test_glitch();
        int e0;
        rab_raw = 1'b1;
        repeat (15) begin
            tick();
            tests++;
            if (rab_level !== 1'b0) begin
                fails++;
                $display("FAIL glitch15_level_high got %b expected 0", rab_level);
            end
        end
        rab_raw = 1'b0;
        repeat (25) begin
            tick();
            tests++;
            if (rab_level !== 1'b0) begin
                fails++;
                $display("FAIL glitch15_level_low got %b expected 0", rab_level);
            end
        end
        e0 = cyc;
        rab_raw = 1'b1;
        rab_q.push_back(e0 + 18);
        for (int i = 0; i < 56; i++) begin
            if (i == 16) rab_raw = 1'b0;
            tick();
            tests++;
            if (rab_level !== (cyc >= e0 + 18 && cyc < e0 + 34)) begin
                fails++;
                $display("FAIL glitch16_level cycle %0d got %b expected %b",
                         cyc - e0, rab_level, cyc >= e0 + 18 && cyc < e0 + 34);
            end
        end
    endtask

    task automatic test_switches();
        sw_raw = 8'h02;
        repeat (4) tick();
        tests++;
        if (sw_sync !== 8'h02) begin
            fails++;
            $display("FAIL sw_initial got %h expected 02", sw_sync);
        end
        sw_raw = 8'hFE;
        tick();
        tests++;
        if (sw_sync !== 8'h02) begin
            fails++;
            $display("FAIL sw_edge1 got %h expected 02", sw_sync);
        end
        tick();
        tests++;
        if (sw_sync !== 8'hFE) begin
            fails++;
            $display("FAIL sw_edge2 got %h expected FE", sw_sync);
        end
        repeat (20) tick();
        tests++;
        if (sw_sync !== 8'hFE || run_level !== 1'b0 || rab_level !== 1'b0) begin
            fails++;
            $display("FAIL sw_isolation sw=%h run=%b rab=%b expected FE 0 0",
                     sw_sync, run_level, rab_level);
        end
    endtask

    task automatic test_reset_mid();
        int e0;
        run_raw = 1'b1;
        repeat (10) tick();
        reset_n = 1'b0;
        tick();
        tests++;
        if ({run_level, run_pulse, rab_level, rab_pulse, sw_sync} !== 12'h000) begin
            fails++;
            $display("FAIL mid_reset_outputs got %b expected all zero",
                     {run_level, run_pulse, rab_level, rab_pulse, sw_sync});
        end
        reset_n = 1'b1;
        e0 = cyc;
        run_q.push_back(e0 + 18);
        repeat (25) begin
            tick();
            tests++;
            if (run_level !== (cyc >= e0 + 18)) begin
                fails++;
                $display("FAIL mid_reset_level cycle %0d got %b expected %b",
                         cyc - e0, run_level, cyc >= e0 + 18);
            end
        end
        run_raw = 1'b0;
        repeat (25) tick();
    endtask

    task automatic test_drain();
        repeat (5) tick();
        tests++;
        if (run_q.size() !== 0) begin
            fails++;
            $display("FAIL run_pulse_missing got %0d outstanding expected 0", run_q.size());
        end
        tests++;
        if (rab_q.size() !== 0) begin
            fails++;
            $display("FAIL rab_pulse_missing got %0d outstanding expected 0", rab_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_switches();
        test_reset_mid();
        test_drain();
        tests += mon_tests;
        fails += mon_fails;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
